// File: rtl/eth_mii_loopback_phy.sv
// MII loopback responder: captures MAC transmit frames into a store-and-forward nibble
// buffer and replays whole frames on the receive side with interframe gap and optional RX_ER.
module eth_mii_loopback_phy #(
  parameter int FIFO_DEPTH  = 4096,
  parameter int IFG_NIBBLES = 24,
  parameter int MIN_NIBBLES = 16,
  parameter int ERR_NIBBLE  = 16,
  parameter bit HALF_DUPLEX = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  mii_txd,
  input  logic        mii_tx_en,
  output logic [3:0]  mii_rxd,
  output logic        mii_rx_dv,
  output logic        mii_rx_er,
  output logic        mii_crs,
  output logic        mii_col,
  input  logic        cfg_loopback_en,
  input  logic        cfg_err_inject,
  output logic [15:0] tx_frame_count,
  output logic [15:0] rx_frame_count,
  output logic [15:0] drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = $clog2(IFG_NIBBLES + 1);
  localparam int LW = $clog2(MIN_NIBBLES + 1);

  typedef enum logic [1:0] {CAP_IDLE, CAP_CAPTURE, CAP_DROP} cap_state_t;
  typedef enum logic [1:0] {RP_IDLE, RP_SEND, RP_GAP} rp_state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  cap_state_t    cap_state;
  rp_state_t     rp_state;
  logic [4:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] len_cnt;
  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] nib_idx;
  logic [3:0]    txd_p0;
  logic          cur_eof;
  logic          err_arm;
  logic          err_active;

  logic          full;
  logic          len_ok;
  logic          wr_attempt;
  logic          mem_we;
  logic          pending;
  logic          gap_done;
  logic          launch;
  logic          advance;
  logic          dv_nxt;
  logic          er_nxt;
  logic [4:0]    rd_entry;
  logic [PW-1:0] nib_idx_nxt;

  // Capture side: the nibble held from the previous cycle is the one written, so the
  // eof flag can be attached once tx_en is seen to drop.
  assign full       = (wr_ptr - rd_ptr) == PW'(FIFO_DEPTH);
  assign len_ok     = len_cnt == LW'(MIN_NIBBLES);
  assign wr_attempt = (cap_state == CAP_CAPTURE) && (mii_tx_en || len_ok);
  assign mem_we     = wr_attempt && !full;

  always_ff @(posedge clock) begin
    if (mii_tx_en) txd_p0 <= mii_txd;
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[wr_ptr[AW-1:0]] <= {!mii_tx_en, txd_p0};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cap_state      <= CAP_IDLE;
      wr_ptr         <= '0;
      commit_ptr     <= '0;
      len_cnt        <= '0;
      tx_frame_count <= '0;
      drop_count     <= '0;
    end else begin
      case (cap_state)
        CAP_IDLE: begin
          if (mii_tx_en && cfg_loopback_en) begin
            cap_state <= CAP_CAPTURE;
            len_cnt   <= LW'(1);
          end
        end
        CAP_CAPTURE: begin
          if (wr_attempt && full) begin
            wr_ptr     <= commit_ptr;
            drop_count <= sat_inc(drop_count);
            cap_state  <= CAP_DROP;
          end else if (mii_tx_en) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (!len_ok) len_cnt <= len_cnt + LW'(1);
          end else begin
            cap_state <= CAP_IDLE;
            if (len_ok) begin
              wr_ptr         <= wr_ptr + PW'(1);
              commit_ptr     <= wr_ptr + PW'(1);
              tx_frame_count <= sat_inc(tx_frame_count);
            end else begin
              wr_ptr     <= commit_ptr;
              drop_count <= sat_inc(drop_count);
            end
          end
        end
        CAP_DROP: begin
          if (!mii_tx_en) cap_state <= CAP_IDLE;
        end
        default: cap_state <= CAP_IDLE;
      endcase
    end
  end

  // Replay side: launching from the last gap cycle keeps the rx_dv-low run at exactly
  // IFG_NIBBLES when the next frame is already waiting.
  assign pending     = commit_ptr != rd_ptr;
  assign gap_done    = gap_cnt == GW'(IFG_NIBBLES - 1);
  assign launch      = pending && ((rp_state == RP_IDLE) || ((rp_state == RP_GAP) && gap_done));
  assign advance     = (rp_state == RP_SEND) && !cur_eof;
  assign dv_nxt      = launch || advance;
  assign rd_entry    = mem[rd_ptr[AW-1:0]];
  assign nib_idx_nxt = launch ? '0 : nib_idx + PW'(1);
  assign er_nxt      = dv_nxt && (launch ? (err_arm || cfg_err_inject) : err_active)
                       && (nib_idx_nxt == PW'(ERR_NIBBLE));

  always_ff @(posedge clock) begin
    if (reset) begin
      rp_state       <= RP_IDLE;
      rd_ptr         <= '0;
      gap_cnt        <= '0;
      nib_idx        <= '0;
      cur_eof        <= 1'b0;
      err_arm        <= 1'b0;
      err_active     <= 1'b0;
      rx_frame_count <= '0;
      mii_rxd        <= '0;
      mii_rx_dv      <= 1'b0;
      mii_rx_er      <= 1'b0;
      mii_crs        <= 1'b0;
      mii_col        <= 1'b0;
    end else begin
      if (launch) begin
        rp_state   <= RP_SEND;
        err_active <= err_arm || cfg_err_inject;
        err_arm    <= 1'b0;
      end else if (cfg_err_inject) begin
        err_arm <= 1'b1;
      end

      if (dv_nxt) begin
        rd_ptr  <= rd_ptr + PW'(1);
        cur_eof <= rd_entry[4];
        nib_idx <= nib_idx_nxt;
      end

      case (rp_state)
        RP_SEND: begin
          if (cur_eof) begin
            rp_state       <= RP_GAP;
            gap_cnt        <= '0;
            rx_frame_count <= sat_inc(rx_frame_count);
          end
        end
        RP_GAP: begin
          if (!gap_done) gap_cnt <= gap_cnt + GW'(1);
          else if (!launch) rp_state <= RP_IDLE;
        end
        default: ;
      endcase

      mii_rx_dv <= dv_nxt;
      mii_rxd   <= dv_nxt ? rd_entry[3:0] : 4'h0;
      mii_rx_er <= er_nxt;
      mii_crs   <= mii_tx_en || dv_nxt;
      mii_col   <= HALF_DUPLEX && mii_tx_en && dv_nxt;
    end
  end

endmodule

// File: tb/tb_eth_mii_loopback_phy.sv
// Bench for eth_mii_loopback_phy: frame-level reference model checked every cycle, a table
// of single-frame scenarios with counter expectations, and directed multi-cycle sequences.
module tb_eth_mii_loopback_phy;
  localparam int DEPTH = 256;
  localparam int IFG   = 24;
  localparam int MINN  = 16;
  localparam int ERRN  = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  mii_txd = '0;
  logic        mii_tx_en = 1'b0;
  logic [3:0]  mii_rxd;
  logic        mii_rx_dv, mii_rx_er, mii_crs, mii_col;
  logic        cfg_loopback_en = 1'b1;
  logic        cfg_err_inject = 1'b0;
  logic [15:0] tx_frame_count, rx_frame_count, drop_count;

  always #5 clock = ~clock;

  eth_mii_loopback_phy #(
    .FIFO_DEPTH(DEPTH), .IFG_NIBBLES(IFG), .MIN_NIBBLES(MINN),
    .ERR_NIBBLE(ERRN), .HALF_DUPLEX(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .mii_txd(mii_txd), .mii_tx_en(mii_tx_en),
    .mii_rxd(mii_rxd), .mii_rx_dv(mii_rx_dv), .mii_rx_er(mii_rx_er),
    .mii_crs(mii_crs), .mii_col(mii_col), .cfg_loopback_en(cfg_loopback_en),
    .cfg_err_inject(cfg_err_inject), .tx_frame_count(tx_frame_count),
    .rx_frame_count(rx_frame_count), .drop_count(drop_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: frames as nibble lists, replay scheduled by commit time and gap.
  typedef struct { int len; longint ready; } frm_t;
  frm_t       m_fq[$];
  logic [3:0] m_nq[$];
  logic [3:0] m_cq[$];
  frm_t       m_f;
  bit         m_cap, m_send, m_err, m_arm, m_prev_tx;
  int         m_pos, m_len, m_tx, m_rx, m_drop;
  longint     m_free, cyc;
  logic       e_dv, e_er, e_crs, e_col;
  logic [3:0] e_d;

  int  dv_idx, er_count, er_pos, col_cycles, low_run, last_gap, dv_cycles;
  bit  seen_frame, prev_dv;

  initial begin
    m_cap = 0; m_send = 0; m_err = 0; m_arm = 0; m_prev_tx = 0;
    m_pos = 0; m_len = 0; m_tx = 0; m_rx = 0; m_drop = 0; m_free = 0; cyc = 0;
    dv_idx = 0; er_count = 0; er_pos = -1; col_cycles = 0; low_run = 0;
    last_gap = -1; dv_cycles = 0; seen_frame = 0; prev_dv = 0;
  end

  always @(negedge clock) begin
    e_dv = 1'b0; e_er = 1'b0; e_d = 4'h0;
    if (!m_send && m_fq.size() > 0 && cyc >= m_fq[0].ready && cyc >= m_free) begin
      m_f = m_fq.pop_front();
      m_len = m_f.len; m_send = 1; m_pos = 0; m_err = m_arm; m_arm = 0;
    end
    if (m_send) begin
      e_dv = 1'b1;
      e_d  = m_nq.pop_front();
      e_er = m_err && (m_pos == ERRN);
      m_pos++;
      if (m_pos == m_len) begin
        m_send = 0; m_free = cyc + IFG + 1; m_rx++;
      end
    end
    e_crs = m_prev_tx | e_dv;
    e_col = m_prev_tx & e_dv;
    check("rx_dv", mii_rx_dv, e_dv);
    check("rxd",   mii_rxd,   e_d);
    check("rx_er", mii_rx_er, e_er);
    check("crs",   mii_crs,   e_crs);
    check("col",   mii_col,   e_col);

    if (mii_rx_dv) begin
      if (!prev_dv) begin
        dv_idx = 0;
        if (seen_frame) last_gap = low_run;
      end else dv_idx++;
      seen_frame = 1; low_run = 0; dv_cycles++;
    end else low_run++;
    if (mii_rx_er) begin er_count++; er_pos = dv_idx; end
    if (mii_col) col_cycles++;
    prev_dv = mii_rx_dv;

    if (reset) begin
      m_fq.delete(); m_nq.delete(); m_cq.delete();
      m_cap = 0; m_send = 0; m_arm = 0; m_err = 0; m_free = 0; m_prev_tx = 0;
      m_tx = 0; m_rx = 0; m_drop = 0;
    end else begin
      m_prev_tx = mii_tx_en;
      if (m_cap) begin
        if (mii_tx_en) m_cq.push_back(mii_txd);
        else begin
          m_cap = 0;
          if (m_cq.size() < MINN || m_cq.size() > DEPTH) m_drop++;
          else begin
            m_fq.push_back('{len: m_cq.size(), ready: cyc + 2});
            foreach (m_cq[i]) m_nq.push_back(m_cq[i]);
            m_tx++;
          end
          m_cq.delete();
        end
      end else if (mii_tx_en && cfg_loopback_en) begin
        m_cap = 1;
        m_cq.push_back(mii_txd);
      end
      if (cfg_err_inject) m_arm = 1;
    end
    cyc++;
  end

  // loop_mode: 0 capture disabled, 1 enabled, 2 enabled at start and dropped mid-frame
  task automatic send_frame(input int len, input int gap, input int loop_mode);
    for (int i = 0; i < len; i++) begin
      @(posedge clock); #1;
      if (i == 0) cfg_loopback_en = (loop_mode != 0);
      if (loop_mode == 2 && i == len / 2) cfg_loopback_en = 1'b0;
      mii_tx_en = 1'b1;
      mii_txd = (i < 15) ? 4'h5 : (i == 15) ? 4'hD : 4'($urandom_range(0, 15));
    end
    @(posedge clock); #1;
    mii_tx_en = 1'b0; mii_txd = 4'h0; cfg_loopback_en = 1'b1;
    repeat (gap - 1) @(posedge clock);
  endtask

  task automatic pulse_inject();
    @(posedge clock); #1 cfg_err_inject = 1'b1;
    @(posedge clock); #1 cfg_err_inject = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int n;
    n = 0;
    while ((m_fq.size() > 0 || m_send || m_cap || mii_tx_en) && n < 5000) begin
      @(posedge clock); n++;
    end
    check({tag, "_timeout"}, (n >= 5000) ? 1 : 0, 0);
    repeat (4) @(posedge clock);
  endtask

  typedef struct { int len; int gap; int loop_mode; int exp_tx; int exp_rx; int exp_drop; int exp_dv; } vec_t;
  vec_t vt[10];

  initial begin
    int n;
    vt[0] = '{144, 30, 1, 1, 1, 0, 144};
    vt[1] = '{300, 30, 1, 1, 1, 1, 0};
    vt[2] = '{100, 30, 1, 2, 2, 1, 100};
    vt[3] = '{8,   30, 1, 2, 2, 2, 0};
    vt[4] = '{15,  30, 1, 2, 2, 3, 0};
    vt[5] = '{16,  30, 1, 3, 3, 3, 16};
    vt[6] = '{50,  30, 0, 3, 3, 3, 0};
    vt[7] = '{60,  30, 2, 4, 4, 3, 60};
    vt[8] = '{256, 30, 1, 5, 5, 3, 256};
    vt[9] = '{257, 30, 1, 5, 5, 4, 0};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_rx_dv", mii_rx_dv, 0);
    check("reset_crs", mii_crs, 0);
    check("reset_tx_count", tx_frame_count, 0);
    check("reset_rx_count", rx_frame_count, 0);
    check("reset_drop_count", drop_count, 0);

    for (int k = 0; k < 10; k++) begin
      dv_cycles = 0;
      send_frame(vt[k].len, vt[k].gap, vt[k].loop_mode);
      wait_quiet($sformatf("vec%0d", k));
      check($sformatf("vec%0d_tx_count", k), tx_frame_count, vt[k].exp_tx);
      check($sformatf("vec%0d_rx_count", k), rx_frame_count, vt[k].exp_rx);
      check($sformatf("vec%0d_drop_count", k), drop_count, vt[k].exp_drop);
      check($sformatf("vec%0d_dv_cycles", k), dv_cycles, vt[k].exp_dv);
    end

    // back-to-back frames with a 12-cycle TX gap; second TX overlaps the first replay
    col_cycles = 0; dv_cycles = 0;
    send_frame(144, 12, 1);
    send_frame(144, 30, 1);
    wait_quiet("b2b");
    check("b2b_ifg", last_gap, IFG);
    check("b2b_col_cycles", col_cycles, 133);
    check("b2b_dv_cycles", dv_cycles, 288);

    // two inject pulses arm once; only the first following frame gets rx_er
    er_count = 0; er_pos = -1;
    pulse_inject();
    repeat (3) @(posedge clock);
    pulse_inject();
    send_frame(144, 30, 1);
    send_frame(60, 30, 1);
    wait_quiet("inject");
    check("inject_er_count", er_count, 1);
    check("inject_er_pos", er_pos, ERRN);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) pulse_inject();
      send_frame($urandom_range(10, 70), $urandom_range(26, 45),
                 ($urandom_range(0, 7) == 0) ? 0 : 1);
    end
    wait_quiet("random");
    check("random_tx_count", tx_frame_count, m_tx);
    check("random_rx_count", rx_frame_count, m_rx);
    check("random_drop_count", drop_count, m_drop);

    // reset during replay nibble 50, then a frame sent with capture disabled
    send_frame(144, 2, 1);
    n = 0;
    while (!(mii_rx_dv && dv_idx == 49) && n < 2000) begin
      @(posedge clock); n++;
    end
    check("rst_wait_timeout", (n >= 2000) ? 1 : 0, 0);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    check("rst_rx_dv", mii_rx_dv, 0);
    check("rst_tx_count", tx_frame_count, 0);
    check("rst_rx_count", rx_frame_count, 0);
    check("rst_drop_count", drop_count, 0);
    dv_cycles = 0;
    repeat (200) @(posedge clock);
    check("rst_no_replay", dv_cycles, 0);
    send_frame(144, 30, 0);
    wait_quiet("noloop");
    check("noloop_tx_count", tx_frame_count, 0);
    check("noloop_rx_count", rx_frame_count, 0);
    check("noloop_drop_count", drop_count, 0);
    check("noloop_dv_cycles", dv_cycles, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
